// File: rtl/cpuc_bus_arb_tristate.sv
// rtl/cpuc_bus_arb_tristate.sv - round-robin arbiter driving a shared tristate data bus
// Define CPUC_BUS_CONTENTION_CHK_EN to build the sticky external-contention checker.
module cpuc_bus_arb_tristate #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_SRC-1:0]                     req,
  input  logic [N_SRC-1:0][DATA_WIDTH-1:0]     src_data,
  input  logic                                 ext_drv,
  output logic [N_SRC-1:0]                     gnt,
  output logic [$clog2(N_SRC)-1:0]             owner,
  output logic                                 bus_valid,
  output logic [DATA_WIDTH-1:0]                bus_data,
  output logic                                 contention_err
);

  localparam int OW = $clog2(N_SRC);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state, state_nx;
  logic [OW-1:0]     owner_nx, rr_ptr, rr_ptr_nx, winner;
  logic [HW-1:0]     hold_cnt, hold_nx;
  logic [TW-1:0]     turn_cnt, turn_nx;
  logic [N_SRC-1:0]  gnt_nx;
  logic [2*N_SRC-1:0] req_rot;
  logic              hold_max, others_req;
  int                w;

  // Rotate the doubled request vector so bit 0 is the source at rr_ptr.
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    w       = 0;
    winner  = rr_ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        w = int'(rr_ptr) + k;
        if (w >= N_SRC) w = w - N_SRC;
        winner = OW'(w);
      end
    end
  end

  assign hold_max   = (hold_cnt == HW'(MAX_HOLD));
  assign others_req = |(req & ~gnt);

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    hold_nx   = hold_cnt;
    turn_nx   = turn_cnt;
    gnt_nx    = gnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx  = GRANT;
          owner_nx  = winner;
          gnt_nx    = N_SRC'(1) << winner;
          hold_nx   = HW'(1);
          rr_ptr_nx = (winner == OW'(N_SRC - 1)) ? '0 : winner + 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner] || (hold_max && others_req)) begin
          state_nx = TURN;
          gnt_nx   = '0;
          turn_nx  = TW'(1);
        end else if (!hold_max) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == TW'(TURNAROUND)) begin
          state_nx = IDLE;
          turn_nx  = '0;
        end else begin
          turn_nx = turn_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      hold_cnt <= hold_nx;
      turn_cnt <= turn_nx;
    end
  end

  // State resets asynchronously, so the bus releases the instant rst_n falls.
  assign bus_valid = (state == GRANT);
  assign bus_data  = bus_valid ? src_data[owner] : {DATA_WIDTH{1'bz}};

`ifdef CPUC_BUS_CONTENTION_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_err <= 1'b0;
    end else if (ext_drv && bus_valid) begin
      contention_err <= 1'b1;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
`else
  logic unused_ext_drv;
  assign unused_ext_drv = ext_drv;
  assign contention_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpuc_bus_arb_tristate.sv
// tb/tb_cpuc_bus_arb_tristate.sv - randomized bench for cpuc_bus_arb_tristate with timestamp-based model
module tb_cpuc_bus_arb_tristate;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 4;
  localparam int TA = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ext_drv = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][DW-1:0] src_data = '0;
  logic [N-1:0]        gnt;
  logic [1:0]          owner;
  logic                bus_valid;
  wire  [DW-1:0]       bus_data;
  logic                contention_err;

  int vectors = 0;
  int errors  = 0;

  // Model: who owns the bus, when the grant began, when the bus was last released.
  int t        = 0;
  int m_owner  = -1;
  int m_gstart = 0;
  int m_rel    = -1000;
  int m_ptr    = 0;
  bit m_cerr   = 1'b0;

  always #5 clk = ~clk;

  cpuc_bus_arb_tristate #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_HOLD(MH), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data), .ext_drv(ext_drv),
    .gnt(gnt), .owner(owner), .bus_valid(bus_valid), .bus_data(bus_data),
    .contention_err(contention_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rel   = -1000;
    m_ptr   = 0;
    m_cerr  = 1'b0;
  endtask

  task automatic model_edge();
    t++;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef CPUC_BUS_CONTENTION_CHK_EN
    if (ext_drv && m_owner >= 0) m_cerr = 1'b1;
`endif
    if (m_owner >= 0) begin
      if (!bit_of(req, m_owner) ||
          ((t - m_gstart) >= MH && (req & ~(N'(1) << m_owner)) != '0)) begin
        m_owner = -1;
        m_rel   = t;
      end
    end else if (t >= m_rel + TA + 1 && req != '0) begin
      int wn;
      wn = -1;
      for (int k = 0; k < N; k++)
        if (wn < 0 && bit_of(req, (m_ptr + k) % N)) wn = (m_ptr + k) % N;
      m_owner  = wn;
      m_gstart = t;
      m_ptr    = (wn + 1) % N;
    end
  endtask

  task automatic check_model();
    chk("gnt", 64'(gnt), (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
    chk("bus_valid", 64'(bus_valid), 64'(m_owner >= 0));
    if (m_owner >= 0) begin
      chk("owner", 64'(owner), 64'(m_owner));
      chk("bus_data", 64'(bus_data), 64'(src_data[m_owner]));
    end
    chk("contention_err", 64'(contention_err), 64'(m_cerr));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [N-1:0] r, input bit rnd);
    req = r;
    if (rnd) src_data = $urandom;
    #1 check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1 model_reset();
    chk("rst_async_gnt", 64'(gnt), 64'h0);
    chk("rst_async_valid", 64'(bus_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] prev;

    req = '1;
    repeat (3) @(negedge clk);
    model_reset();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_valid", 64'(bus_valid), 64'h0);
    chk("rst_cerr", 64'(contention_err), 64'h0);
    rst_n = 1'b1;
    step('1, 1'b1);
    chk("rst_release_gnt", 64'(gnt), 64'h1);
    repeat (3) step('0, 1'b1);

    src_data    = '0;
    src_data[2] = 8'hA5;
    step(4'b0100, 1'b0);
    chk("single_data0", 64'(bus_data), 64'hA5);
    chk("single_gnt0", 64'(gnt), 64'h4);
    step(4'b0100, 1'b0);
    chk("single_data1", 64'(bus_data), 64'hA5);
    step(4'b0000, 1'b0);
    chk("single_turn_gnt", 64'(gnt), 64'h0);
    chk("single_turn_valid", 64'(bus_valid), 64'h0);
    repeat (2) step('0, 1'b1);

    pulse_reset();
    for (int c = 0; c < 28; c++) begin
      step('1, 1'b1);
      chk("rr_gnt", 64'(gnt), ((c % 6) < 4) ? (64'd1 << ((c / 6) % 4)) : 64'd0);
    end
    repeat (3) step('0, 1'b1);

    for (int c = 0; c < 10; c++) begin
      step(4'b0010, 1'b1);
      chk("hold_sat_gnt", 64'(gnt), 64'h2);
    end
    repeat (3) step('0, 1'b1);

    step(4'b1000, 1'b1);
    chk("async_owner", 64'(owner), 64'h3);
    chk("async_gnt_before", 64'(gnt), 64'h8);
    #2 pulse_reset();

    step(4'b0001, 1'b1);
    ext_drv = 1'b1;
    step(4'b0001, 1'b1);
    ext_drv = 1'b0;
`ifdef CPUC_BUS_CONTENTION_CHK_EN
    chk("cont_set", 64'(contention_err), 64'h1);
    repeat (4) step('0, 1'b1);
    chk("cont_sticky", 64'(contention_err), 64'h1);
`else
    chk("cont_tied", 64'(contention_err), 64'h0);
    repeat (4) step('0, 1'b1);
    chk("cont_tied_later", 64'(contention_err), 64'h0);
`endif
    pulse_reset();
    chk("cont_cleared", 64'(contention_err), 64'h0);

    prev = '0;
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r       = prev ^ (N'($urandom) & N'($urandom));
      ext_drv = ($urandom_range(0, 19) == 0);
      step(r, 1'b1);
      prev = r;
      if (i % 200 == 199) pulse_reset();
    end
    ext_drv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
